// File: rtl/id_stage.sv
// Instruction decode stage: 15-entry register file with write-through, opcode decode,
// condition evaluation and load-use/RAW hazard detection. All outputs are combinational.
module id_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic [31:0] pc_in,
   input  logic [3:0]  sr,
   input  logic        wb_en,
   input  logic [3:0]  wb_dest,
   input  logic [31:0] wb_value,
   input  logic        exe_wb_en,
   input  logic [3:0]  exe_dest,
   input  logic        mem_wb_en,
   input  logic [3:0]  mem_dest,
   input  logic        flush,
   output logic        wb_en_out,
   output logic        mem_r_en,
   output logic        mem_w_en,
   output logic        b,
   output logic        s,
   output logic        imm,
   output logic [3:0]  exe_cmd,
   output logic [31:0] pc_out,
   output logic [31:0] val_rn,
   output logic [31:0] val_rm,
   output logic [11:0] shift_operand,
   output logic [23:0] signed_imm_24,
   output logic [3:0]  dest,
   output logic        c_out,
   output logic        hazard
);

   localparam int unsigned NUM_REGS = 15;
   localparam int unsigned DW       = 32;
   localparam int unsigned AW       = 4;
   localparam logic [AW-1:0] PC_ADDR = AW'(15);

   logic [DW-1:0] rf_q [NUM_REGS];
   logic [DW-1:0] rf_d [NUM_REGS];

   logic [3:0]    cond, opcode;
   logic [1:0]    mode;
   logic          i_bit, s_bit;
   logic [AW-1:0] rn_addr, rm_addr;
   logic          wb_live;

   assign cond    = instr[31:28];
   assign mode    = instr[27:26];
   assign i_bit   = instr[25];
   assign opcode  = instr[24:21];
   assign s_bit   = instr[20];
   assign wb_live = wb_en && reset && (wb_dest != PC_ADDR);

   // Register file update; index 15 is the PC and never stored
   always_comb begin
      rf_d = rf_q;
      if (wb_live) rf_d[wb_dest] = wb_value;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else begin
         rf_q <= rf_d;
      end
   end

   // Decoded controls before squashing
   logic       dec_wb, dec_mr, dec_mw, dec_b, dec_s, is_str;
   logic [3:0] dec_cmd;

   always_comb begin
      dec_wb  = 1'b0;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_b   = 1'b0;
      dec_s   = 1'b0;
      dec_cmd = 4'b0000;
      is_str  = 1'b0;
      unique case (mode)
         2'b00: begin
            dec_wb = 1'b1;
            dec_s  = s_bit;
            case (opcode)
               4'b1101: dec_cmd = 4'b0001;
               4'b1111: dec_cmd = 4'b1001;
               4'b0100: dec_cmd = 4'b0010;
               4'b0101: dec_cmd = 4'b0011;
               4'b0010: dec_cmd = 4'b0100;
               4'b0110: dec_cmd = 4'b0101;
               4'b0000: dec_cmd = 4'b0110;
               4'b1100: dec_cmd = 4'b0111;
               4'b0001: dec_cmd = 4'b1000;
               4'b1010: begin dec_cmd = 4'b0100; dec_wb = 1'b0; dec_s = 1'b1; end
               4'b1000: begin dec_cmd = 4'b0110; dec_wb = 1'b0; dec_s = 1'b1; end
               default: begin dec_wb = 1'b0; dec_s = 1'b0; end
            endcase
         end
         2'b01: begin
            dec_cmd = 4'b0010;
            dec_mr  = s_bit;
            dec_wb  = s_bit;
            dec_mw  = !s_bit;
            is_str  = !s_bit;
         end
         2'b10:   dec_b = 1'b1;
         default: ;
      endcase
   end

   assign rn_addr = instr[19:16];
   assign rm_addr = is_str ? instr[15:12] : instr[3:0];

   // Read ports: PC at address 15, same-cycle write-through otherwise
   always_comb begin
      if (rn_addr == PC_ADDR)                    val_rn = pc_in;
      else if (wb_live && (wb_dest == rn_addr))  val_rn = wb_value;
      else                                       val_rn = rf_q[rn_addr];
      if (rm_addr == PC_ADDR)                    val_rm = pc_in;
      else if (wb_live && (wb_dest == rm_addr))  val_rm = wb_value;
      else                                       val_rm = rf_q[rm_addr];
   end

   logic flag_n, flag_z, flag_c, flag_v, cond_ok;
   assign {flag_n, flag_z, flag_c, flag_v} = sr;

   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         4'b0000: cond_ok = flag_z;
         4'b0001: cond_ok = !flag_z;
         4'b0010: cond_ok = flag_c;
         4'b0011: cond_ok = !flag_c;
         4'b0100: cond_ok = flag_n;
         4'b0101: cond_ok = !flag_n;
         4'b0110: cond_ok = flag_v;
         4'b0111: cond_ok = !flag_v;
         4'b1000: cond_ok = flag_c && !flag_z;
         4'b1001: cond_ok = !flag_c || flag_z;
         4'b1010: cond_ok = (flag_n == flag_v);
         4'b1011: cond_ok = (flag_n != flag_v);
         4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
         4'b1101: cond_ok = flag_z || (flag_n != flag_v);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   // RAW hazard against in-flight destinations; write-through does not clear it
   logic src1_used, src2_used, raw_haz, bubble;
   assign src1_used = !((mode == 2'b10) ||
                        ((mode == 2'b00) && ((opcode == 4'b1101) || (opcode == 4'b1111))));
   assign src2_used = ((mode == 2'b00) && !i_bit) || is_str;
   assign raw_haz   = (src1_used && ((exe_wb_en && (rn_addr == exe_dest)) ||
                                     (mem_wb_en && (rn_addr == mem_dest)))) ||
                      (src2_used && ((exe_wb_en && (rm_addr == exe_dest)) ||
                                     (mem_wb_en && (rm_addr == mem_dest))));
   assign hazard    = raw_haz && !flush;
   assign bubble    = !cond_ok || raw_haz || flush;

   assign wb_en_out     = dec_wb && !bubble;
   assign mem_r_en      = dec_mr && !bubble;
   assign mem_w_en      = dec_mw && !bubble;
   assign b             = dec_b  && !bubble;
   assign s             = dec_s  && !bubble;
   assign exe_cmd       = bubble ? 4'b0000 : dec_cmd;
   assign imm           = i_bit;
   assign pc_out        = pc_in;
   assign shift_operand = instr[11:0];
   assign signed_imm_24 = instr[23:0];
   assign dest          = instr[15:12];
   assign c_out         = flag_c;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  asynchronous, active-low; clears register file while low.
REQ-003 instr  in  32  fetched instruction: [31:28] cond, [27:26] mode, [25] I, [24:21] opcode, [20] S, [19:16] Rn, [15:12] Rd, [11:0] shift operand, [23:0] signed imm24.
REQ-004 pc_in  in  32  PC+4 of instr; passed to pc_out.
REQ-005 sr  in  4  status flags {N,Z,C,V} from EXE.
REQ-006 wb_en, wb_dest, wb_value  in  1/4/32  write-back port.
REQ-007 exe_wb_en, exe_dest, mem_wb_en, mem_dest  in  1/4/1/4  in-flight destinations for hazard check.
REQ-008 flush  in  1  branch taken in EXE; squash this instruction.
REQ-009 wb_en_out, mem_r_en, mem_w_en, b, s, imm  out  1 each  control to ID/EXE register.
REQ-010 exe_cmd  out  4; pc_out  out  32; val_rn, val_rm  out  32 each; shift_operand  out  12; signed_imm_24  out  24; dest  out  4; c_out  out  1 (= sr C).
REQ-011 hazard  out  1  stall request to IF stage and IF/ID register.

Function
REQ-012 Register file: 15 x 32 (R0..R14); write on rising clk when wb_en=1 and wb_dest!=15; writes to 15 ignored.
REQ-013 Read port 1 address = Rn; read port 2 address = Rd when mem_w_en (STR), else Rm (instr[3:0]).
REQ-014 Reads are combinational; if wb_en=1 and wb_dest equals a read address (!=15), that port returns wb_value same cycle (write-through).
REQ-015 Read of address 15 returns pc_in.
REQ-016 Decode, mode 00: opcode MOV 1101->exe_cmd 0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110; wb_en_out=1 except CMP/TST; s=instr[20], forced 1 for CMP/TST.
REQ-017 Mode 01: S=1 -> LDR (exe_cmd 0010, mem_r_en=1, wb_en_out=1); S=0 -> STR (exe_cmd 0010, mem_w_en=1); s output 0.
REQ-018 Mode 10: b=1, all other controls 0, exe_cmd 0000; unknown opcodes/mode 11 produce all controls 0.
REQ-019 Condition check on cond vs sr: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
REQ-020 Hazard: src1 used unless MOV/MVN/B; src2 used when (mode 00 and I=0) or STR; hazard=1 if a used source equals exe_dest with exe_wb_en=1 or mem_dest with mem_wb_en=1.
REQ-021 If condition fails, hazard=1, or flush=1: wb_en_out, mem_r_en, mem_w_en, b, s forced 0 and exe_cmd 0000 (bubble); data outputs unaffected.
REQ-022 flush=1 forces hazard=0.
REQ-023 dest=Rd; imm=instr[25]; shift_operand=instr[11:0]; signed_imm_24=instr[23:0]; all outputs combinational (zero latency) from inputs and register file.
REQ-024 Simultaneous write and hazard on same register: hazard rule applies unchanged (write-through does not clear it).

Reset
REQ-025 reset=0 clears R0..R14 to 0 asynchronously; writes blocked while reset=0.
REQ-026 reset mid-operation: first write after reset release occurs on the first rising clk with reset=1.

Verification
REQ-027 Reset, then write R3=0x0000_00A5, next cycle ADD R1,R3,R3 (I=0) -> val_rn=val_rm=0xA5, exe_cmd 0010, wb_en_out=1.
REQ-028 wb_en=1 wb_dest=2 wb_value=0x1234 same cycle as MOV R0,R2 -> val_rm=0x1234, no hazard.
REQ-029 exe_dest=4 exe_wb_en=1, instr SUB R5,R4,#1 -> hazard=1, all controls 0; with MOV R5,#1 -> hazard=0.
REQ-030 sr=0100 (Z=1), BNE -> b=0; BEQ -> b=1; flush=1 with BEQ -> b=0, hazard=0.
REQ-031 STR R7,[R2] -> val_rm=R7 contents, mem_w_en=1, wb_en_out=0; write to wb_dest=15 leaves file unchanged.
REQ-032 Load R9=0xFFFF_FFFF, assert reset=0 asynchronously mid-cycle -> R9 reads 0 immediately.
